// File: rtl/smart_home_ctrl_if.sv
// smart_home_ctrl_if -- pin-level bundle between raw sensors / actuator drivers
// and the supervisory controller.
//   master : sensor side (drives SFD, SRD, SW, SFA, Ack, ST; observes actuators)
//   slave  : controller side (reverse directions)
// Optional: SMART_HOME_ALARM_LOG_EN adds the 8-bit alarm_cnt observation signal.
interface smart_home_ctrl_if #(
   parameter int TW   = 7,
   parameter int NWIN = 2
);
   logic            SFD;
   logic            SRD;
   logic [NWIN-1:0] SW;
   logic            SFA;
   logic            Ack;
   logic [TW-1:0]   ST;
   logic            fdoor;
   logic            rdoor;
   logic            winbuzz;
   logic            alarmbuzz;
   logic            heater;
   logic            cooler;
   logic [NWIN-1:0] win_mask;
   logic [2:0]      display;
`ifdef SMART_HOME_ALARM_LOG_EN
   logic [7:0]      alarm_cnt;

   modport master (output SFD, SRD, SW, SFA, Ack, ST,
                   input  fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler,
                          win_mask, display, alarm_cnt);
   modport slave  (input  SFD, SRD, SW, SFA, Ack, ST,
                   output fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler,
                          win_mask, display, alarm_cnt);
`else
   modport master (output SFD, SRD, SW, SFA, Ack, ST,
                   input  fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler,
                          win_mask, display);
   modport slave  (input  SFD, SRD, SW, SFA, Ack, ST,
                   output fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler,
                          win_mask, display);
`endif
endinterface

// File: rtl/smart_home_ctrl.sv
// smart_home_ctrl -- home supervisory controller.
// Raw door/window/fire pins are synchronised and debounced per bit, the
// temperature is compared against hysteresis thresholds, and a single
// priority Moore FSM picks the active function; its state code is the display.
//   Clk, Rst  : clock (rising edge), asynchronous active-low reset
//   bus.slave : sensors in (SFD, SRD, SW, SFA, Ack, ST),
//               actuators/display out (fdoor, rdoor, winbuzz, alarmbuzz,
//               heater, cooler, win_mask, display)
// Optional: define SMART_HOME_ALARM_LOG_EN to add bus.alarm_cnt, a saturating
// count of ALARM entries.

// One sensor lane: 2-flop synchroniser plus debounce counter.
module smart_home_deb #(
   parameter int DEB_CYC = 4
)(
   input  logic Clk,
   input  logic Rst,
   input  logic raw,
   output logic deb,
   output logic flip   // deb toggles on this edge
);
   localparam int CW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);

   logic          s1, s2;
   logic [CW-1:0] cnt;

   // cnt holds the number of differing cycles already seen, so the edge that
   // sees the DEB_CYC-th one is where deb flips.
   assign flip = (s2 != deb) && (cnt == CW'(DEB_CYC - 1));

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         s1  <= 1'b0;
         s2  <= 1'b0;
         deb <= 1'b0;
         cnt <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (s2 != deb) begin
            if (flip) begin
               deb <= ~deb;
               cnt <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end
endmodule

module smart_home_ctrl #(
   parameter int TW        = 7,
   parameter int NWIN      = 2,
   parameter int T_HEAT_ON = 50,
   parameter int T_COOL_ON = 85,
   parameter int HYST      = 2,
   parameter int DEB_CYC   = 4,
   parameter int DOOR_HOLD = 16
)(
   input  logic             Clk,
   input  logic             Rst,
   smart_home_ctrl_if.slave bus
);
   localparam int NS = NWIN + 3;   // SFD, SRD, SFA, SW[NWIN-1:0]
   localparam int HW = $clog2(DOOR_HOLD + 1);

   localparam logic [TW:0] HEAT_SET = (TW+1)'(T_HEAT_ON);
   localparam logic [TW:0] HEAT_CLR = (TW+1)'(T_HEAT_ON + HYST);
   localparam logic [TW:0] COOL_SET = (TW+1)'(T_COOL_ON);
   localparam logic [TW:0] COOL_CLR = (TW+1)'(T_COOL_ON - HYST);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FDOOR = 3'd1,
      S_RDOOR = 3'd2,
      S_WIN   = 3'd3,
      S_ALARM = 3'd4,
      S_HEAT  = 3'd5,
      S_COOL  = 3'd6
   } state_t;

   // ---------------- sensor lanes ----------------
   logic [NS-1:0] raw, deb, flip;
   assign raw = {bus.SW, bus.SFA, bus.SRD, bus.SFD};

   for (genvar i = 0; i < NS; i++) begin : g_lane
      smart_home_deb #(.DEB_CYC(DEB_CYC)) u_deb (
         .Clk  (Clk),
         .Rst  (Rst),
         .raw  (raw[i]),
         .deb  (deb[i]),
         .flip (flip[i])
      );
   end

   logic            sfd_d, srd_d, sfa_d;
   logic [NWIN-1:0] sw_d;
   logic            sfd_fall, srd_fall;
   logic            unused_flip;
   assign sfd_d       = deb[0];
   assign srd_d       = deb[1];
   assign sfa_d       = deb[2];
   assign sw_d        = deb[NS-1:3];
   assign sfd_fall    = deb[0] & flip[0];
   assign srd_fall    = deb[1] & flip[1];
   assign unused_flip = ^flip[NS-1:2];

   // ---------------- temperature ----------------
   logic [TW-1:0] st_q;
   logic [TW:0]   st_x;
   logic          heat_req, cool_req;
   assign st_x = {1'b0, st_q};

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         st_q     <= '0;
         heat_req <= 1'b0;
         cool_req <= 1'b0;
      end else begin
         st_q <= bus.ST;
         if (st_x < HEAT_SET)       heat_req <= 1'b1;
         else if (st_x >= HEAT_CLR) heat_req <= 1'b0;
         if (st_x > COOL_SET)       cool_req <= 1'b1;
         else if (st_x <= COOL_CLR) cool_req <= 1'b0;
      end
   end

   // ---------------- FSM + door hold ----------------
   state_t        state, state_nx, prio;
   logic [HW-1:0] hold_tmr;
   logic          hold_act, fd_req, rd_req;
   logic          door_st, cur_fall, cur_d;

   // The hold keeps the door request alive only if the timer is still nonzero
   // after this edge's decrement, so the door closes on the edge it hits 0.
   assign hold_act = (hold_tmr > HW'(1));
   assign fd_req   = sfd_d | ((state == S_FDOOR) & hold_act);
   assign rd_req   = srd_d | ((state == S_RDOOR) & hold_act);

   assign door_st  = (state == S_FDOOR) || (state == S_RDOOR);
   assign cur_fall = (state == S_FDOOR) ? sfd_fall : srd_fall;
   assign cur_d    = (state == S_FDOOR) ? sfd_d : srd_d;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      prio = S_IDLE;
      if (sfa_d)         prio = S_ALARM;
      else if (fd_req)   prio = S_FDOOR;
      else if (rd_req)   prio = S_RDOOR;
      else if (|sw_d)    prio = S_WIN;
      else if (heat_req) prio = S_HEAT;
      else if (cool_req) prio = S_COOL;

      state_nx = S_IDLE;
      case (state)
         S_ALARM: state_nx = (!sfa_d && bus.Ack) ? prio : S_ALARM;
         S_IDLE, S_FDOOR, S_RDOOR, S_WIN, S_HEAT, S_COOL: state_nx = prio;
         default: state_nx = S_IDLE;
      endcase
   end

   // Shared by both doors: only the door that owns the current state can arm
   // it, and any departure from that state (e.g. preemption) drops it.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)                              hold_tmr <= '0;
      else if (door_st && state_nx != state) hold_tmr <= '0;
      else if (door_st && cur_fall)          hold_tmr <= HW'(DOOR_HOLD);
      else if (door_st && cur_d)             hold_tmr <= '0;
      else if (hold_tmr != '0)               hold_tmr <= hold_tmr - 1'b1;
   end

   logic fdoor_o, rdoor_o, winbuzz_o, alarmbuzz_o, heater_o, cooler_o;

   always_comb begin
      fdoor_o     = 1'b0;
      rdoor_o     = 1'b0;
      winbuzz_o   = 1'b0;
      alarmbuzz_o = 1'b0;
      heater_o    = 1'b0;
      cooler_o    = 1'b0;
      case (state)
         S_FDOOR: fdoor_o   = 1'b1;
         S_RDOOR: rdoor_o   = 1'b1;
         S_WIN:   winbuzz_o = 1'b1;
         S_ALARM: begin        // evacuation: both doors open
            alarmbuzz_o = 1'b1;
            fdoor_o     = 1'b1;
            rdoor_o     = 1'b1;
         end
         S_HEAT:  heater_o  = 1'b1;
         S_COOL:  cooler_o  = 1'b1;
         default: ;
      endcase
   end

   assign bus.fdoor     = fdoor_o;
   assign bus.rdoor     = rdoor_o;
   assign bus.winbuzz   = winbuzz_o;
   assign bus.alarmbuzz = alarmbuzz_o;
   assign bus.heater    = heater_o;
   assign bus.cooler    = cooler_o;
   assign bus.win_mask  = sw_d;
   assign bus.display   = state;

`ifdef SMART_HOME_ALARM_LOG_EN
   logic [7:0] alarm_cnt;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         alarm_cnt <= '0;
      else if (state_nx == S_ALARM && state != S_ALARM && alarm_cnt != 8'hFF)
         alarm_cnt <= alarm_cnt + 8'd1;
   end

   assign bus.alarm_cnt = alarm_cnt;
`endif
endmodule
